// File: rtl/alu_operand_select.sv
`default_nettype none
// ============================================================================
// alu_operand_select : Y86-64 execute-stage ALU operand and function selector
// Revision: 1.0
// ============================================================================
module alu_operand_select (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [3:0]  icode,
  input  logic [3:0]  ifun,
  input  logic [63:0] valA,
  input  logic [63:0] valB,
  input  logic [63:0] valC,
  output logic [63:0] aluA,
  output logic [63:0] aluB,
  output logic [1:0]  alufun,
  output logic        op_err
);

  localparam logic [3:0] C_ICODE_RRMOVQ = 4'h2;
  localparam logic [3:0] C_ICODE_IRMOVQ = 4'h3;
  localparam logic [3:0] C_ICODE_RMMOVQ = 4'h4;
  localparam logic [3:0] C_ICODE_MRMOVQ = 4'h5;
  localparam logic [3:0] C_ICODE_OPQ    = 4'h6;
  localparam logic [3:0] C_ICODE_CALL   = 4'h8;
  localparam logic [3:0] C_ICODE_RET    = 4'h9;
  localparam logic [3:0] C_ICODE_PUSHQ  = 4'hA;
  localparam logic [3:0] C_ICODE_POPQ   = 4'hB;

  localparam logic [63:0] C_STACK_DEC = 64'hFFFF_FFFF_FFFF_FFF8;
  localparam logic [63:0] C_STACK_INC = 64'h0000_0000_0000_0008;
  localparam logic [1:0]  C_FUN_ADD   = 2'd0;

  logic [63:0] w_alu_a;
  logic [63:0] w_alu_b;
  logic [1:0]  w_alu_fun;
  logic        w_op_err;

  logic [63:0] r_alu_a;
  logic [63:0] r_alu_b;
  logic [1:0]  r_alu_fun;
  logic        r_op_err;

  always_comb begin
    w_alu_a = '0;
    unique case (icode)
      C_ICODE_RRMOVQ, C_ICODE_OPQ:                  w_alu_a = valA;
      C_ICODE_IRMOVQ, C_ICODE_RMMOVQ, C_ICODE_MRMOVQ: w_alu_a = valC;
      C_ICODE_CALL, C_ICODE_PUSHQ:                  w_alu_a = C_STACK_DEC;
      C_ICODE_RET, C_ICODE_POPQ:                    w_alu_a = C_STACK_INC;
      default:                                      w_alu_a = '0;
    endcase
  end

  always_comb begin
    w_alu_b = '0;
    unique case (icode)
      C_ICODE_RMMOVQ, C_ICODE_MRMOVQ, C_ICODE_OPQ,
      C_ICODE_CALL, C_ICODE_RET, C_ICODE_PUSHQ, C_ICODE_POPQ: w_alu_b = valB;
      default:                                                w_alu_b = '0;
    endcase
  end

  // Only OPq consults ifun; undefined OPq functions fall back to add and flag.
  always_comb begin
    w_alu_fun = C_FUN_ADD;
    w_op_err  = 1'b0;
    if (icode == C_ICODE_OPQ) begin
      if (ifun[3:2] == 2'b00) begin
        w_alu_fun = ifun[1:0];
      end else begin
        w_op_err  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_alu_a   <= '0;
      r_alu_b   <= '0;
      r_alu_fun <= C_FUN_ADD;
      r_op_err  <= 1'b0;
    end else if (en) begin
      r_alu_a   <= w_alu_a;
      r_alu_b   <= w_alu_b;
      r_alu_fun <= w_alu_fun;
      r_op_err  <= w_op_err;
    end
  end

  assign aluA   = r_alu_a;
  assign aluB   = r_alu_b;
  assign alufun = r_alu_fun;
  assign op_err = r_op_err;

endmodule
`default_nettype wire

// File: tb/tb_alu_operand_select.sv
`default_nettype none
// ============================================================================
// tb_alu_operand_select : directed self-checking bench for alu_operand_select
// Revision: 1.0
// ============================================================================
module tb_alu_operand_select;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [3:0]  icode;
  logic [3:0]  ifun;
  logic [63:0] valA;
  logic [63:0] valB;
  logic [63:0] valC;
  logic [63:0] aluA;
  logic [63:0] aluB;
  logic [1:0]  alufun;
  logic        op_err;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  alu_operand_select dut (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .icode  (icode),
    .ifun   (ifun),
    .valA   (valA),
    .valB   (valB),
    .valC   (valC),
    .aluA   (aluA),
    .aluB   (aluB),
    .alufun (alufun),
    .op_err (op_err)
  );

  // Present inputs, then step one rising edge and settle 1 time unit past it.
  task automatic drive_step(input logic [3:0] ic, input logic [3:0] fn,
                            input logic [63:0] a, input logic [63:0] b,
                            input logic [63:0] c, input logic e);
    icode = ic; ifun = fn; valA = a; valB = b; valC = c; en = e;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    logic [130:0] obs;
    rst = 1'b1; en = 1'b1;
    icode = 4'h6; ifun = 4'h1; valA = 64'h5; valB = 64'h7; valC = 64'h9;
    #3;
    obs = {aluA, aluB, alufun, op_err};
    checks++;
    if (obs !== 131'd0) begin
      errors++;
      $display("FAIL reset_initial: got %h expected 0", obs);
    end
    @(negedge clk);
    rst = 1'b0;
    drive_step(4'h6, 4'h3, 64'h11, 64'h22, 64'h0, 1'b1);
    checks++;
    if ({aluA, aluB, alufun, op_err} !== {64'h11, 64'h22, 2'd3, 1'b0}) begin
      errors++;
      $display("FAIL reset_preload: got %h/%h/%0d/%0d expected 11/22/3/0",
               aluA, aluB, alufun, op_err);
    end
    drive_step(4'h6, 4'h9, 64'h11, 64'h22, 64'h0, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    obs = {aluA, aluB, alufun, op_err};
    checks++;
    if (obs !== 131'd0) begin
      errors++;
      $display("FAIL reset_async: got %h expected 0", obs);
    end
    for (int i = 0; i < 3; i++) begin
      drive_step(4'h6, 4'h2, 64'hAA, 64'hBB, 64'hCC, 1'b1);
      obs = {aluA, aluB, alufun, op_err};
      checks++;
      if (obs !== 131'd0) begin
        errors++;
        $display("FAIL reset_hold cycle %0d: got %h expected 0", i, obs);
      end
    end
    @(negedge clk);
    rst = 1'b0;
    icode = 4'h9; ifun = 4'h0; valA = 64'h0; valB = 64'h55; valC = 64'h0; en = 1'b1;
    #2;
    checks++;
    if ({aluA, aluB, alufun, op_err} !== 131'd0) begin
      errors++;
      $display("FAIL reset_release_no_replay: got %h/%h expected 0/0", aluA, aluB);
    end
    @(posedge clk);
    #1;
    checks++;
    if ({aluA, aluB, alufun, op_err} !== {64'h8, 64'h55, 2'd0, 1'b0}) begin
      errors++;
      $display("FAIL reset_first_capture: got %h/%h/%0d/%0d expected 8/55/0/0",
               aluA, aluB, alufun, op_err);
    end
  endtask

  task automatic test_opq;
    logic [3:0] fn_tab  [5] = '{4'h1, 4'h0, 4'h2, 4'h3, 4'h7};
    logic [1:0] fun_exp [5] = '{2'd1, 2'd0, 2'd2, 2'd3, 2'd0};
    logic       err_exp [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 5; i++) begin
      drive_step(4'h6, fn_tab[i], 64'd5, 64'd12, 64'hDEAD, 1'b1);
      checks++;
      if ({aluA, aluB, alufun, op_err} !== {64'd5, 64'd12, fun_exp[i], err_exp[i]}) begin
        errors++;
        $display("FAIL opq ifun=%0d: got %h/%h/%0d/%0d expected 5/c/%0d/%0d",
                 fn_tab[i], aluA, aluB, alufun, op_err, fun_exp[i], err_exp[i]);
      end
    end
    drive_step(4'h6, 4'hF, 64'd1, 64'd2, 64'd0, 1'b1);
    checks++;
    if ({alufun, op_err} !== {2'd0, 1'b1}) begin
      errors++;
      $display("FAIL opq ifun=f: got %0d/%0d expected 0/1", alufun, op_err);
    end
  endtask

  task automatic test_stack;
    logic [3:0]  ic_tab [4] = '{4'hA, 4'h8, 4'h9, 4'hB};
    logic [63:0] vb_tab [4] = '{64'h100, 64'h100, 64'hF8, 64'hF8};
    logic [63:0] a_exp  [4] = '{64'hFFFF_FFFF_FFFF_FFF8, 64'hFFFF_FFFF_FFFF_FFF8, 64'h8, 64'h8};
    for (int i = 0; i < 4; i++) begin
      drive_step(ic_tab[i], 4'h5, 64'h77, vb_tab[i], 64'h66, 1'b1);
      checks++;
      if ({aluA, aluB, alufun, op_err} !== {a_exp[i], vb_tab[i], 2'd0, 1'b0}) begin
        errors++;
        $display("FAIL stack icode=%h: got %h/%h/%0d/%0d expected %h/%h/0/0",
                 ic_tab[i], aluA, aluB, alufun, op_err, a_exp[i], vb_tab[i]);
      end
    end
  endtask

  task automatic test_const;
    logic [3:0]  ic_tab [4] = '{4'h3, 4'h4, 4'h5, 4'h2};
    logic [3:0]  fn_tab [4] = '{4'h0, 4'h0, 4'h0, 4'h3};
    logic [63:0] a_exp  [4] = '{64'h1234, 64'h1234, 64'h1234, 64'h99};
    logic [63:0] b_exp  [4] = '{64'h0, 64'h40, 64'h40, 64'h0};
    for (int i = 0; i < 4; i++) begin
      drive_step(ic_tab[i], fn_tab[i], 64'h99, 64'h40, 64'h1234, 1'b1);
      checks++;
      if ({aluA, aluB, alufun, op_err} !== {a_exp[i], b_exp[i], 2'd0, 1'b0}) begin
        errors++;
        $display("FAIL const icode=%h: got %h/%h/%0d/%0d expected %h/%h/0/0",
                 ic_tab[i], aluA, aluB, alufun, op_err, a_exp[i], b_exp[i]);
      end
    end
  endtask

  task automatic test_default;
    logic [3:0] ic_tab [7] = '{4'h0, 4'h1, 4'h7, 4'hC, 4'hD, 4'hE, 4'hF};
    for (int i = 0; i < 7; i++) begin
      drive_step(4'h6, 4'h1, 64'h3, 64'h3, 64'h3, 1'b1);
      drive_step(ic_tab[i], 4'h2, '1, '1, '1, 1'b1);
      checks++;
      if ({aluA, aluB, alufun, op_err} !== 131'd0) begin
        errors++;
        $display("FAIL default icode=%h: got %h/%h/%0d/%0d expected 0/0/0/0",
                 ic_tab[i], aluA, aluB, alufun, op_err);
      end
    end
  endtask

  task automatic test_enable_hold;
    drive_step(4'h6, 4'h2, 64'd3, 64'd4, 64'd0, 1'b1);
    checks++;
    if ({aluA, aluB, alufun, op_err} !== {64'd3, 64'd4, 2'd2, 1'b0}) begin
      errors++;
      $display("FAIL hold_load: got %h/%h/%0d/%0d expected 3/4/2/0",
               aluA, aluB, alufun, op_err);
    end
    for (int i = 0; i < 3; i++) begin
      drive_step(4'hA, 4'h9 + 4'(i), 64'h10 + 64'(i), 64'h20 + 64'(i), 64'h30, 1'b0);
      checks++;
      if ({aluA, aluB, alufun, op_err} !== {64'd3, 64'd4, 2'd2, 1'b0}) begin
        errors++;
        $display("FAIL hold_en0 cycle %0d: got %h/%h/%0d/%0d expected 3/4/2/0",
                 i, aluA, aluB, alufun, op_err);
      end
    end
    icode = 4'h6; ifun = 4'h3; valA = 64'h70; valB = 64'h80; en = 1'b1;
    #3;
    checks++;
    if ({aluA, aluB, alufun} !== {64'd3, 64'd4, 2'd2}) begin
      errors++;
      $display("FAIL between_edges: got %h/%h/%0d expected 3/4/2", aluA, aluB, alufun);
    end
    @(posedge clk);
    #1;
    checks++;
    if ({aluA, aluB, alufun, op_err} !== {64'h70, 64'h80, 2'd3, 1'b0}) begin
      errors++;
      $display("FAIL hold_en1: got %h/%h/%0d/%0d expected 70/80/3/0",
               aluA, aluB, alufun, op_err);
    end
  endtask

  initial begin
    test_reset();
    test_opq();
    test_stack();
    test_const();
    test_default();
    test_enable_hold();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
